// File: rtl/usb_clk_pkg.sv
// ============================================================================
// Module   : usb_clk_pkg
// Purpose  : Shared state encoding, USB clocking constants and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RUN       = 2'd2
    } usb_clk_state_e;

    localparam int USB_FS_CLK_DIV     = 4;
    localparam int USB_SOF_CYCLES_48M = 48000;

    // A counter that must hold values 0..n-1 needs at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_sync_ff.sv
// ============================================================================
// Module   : usb_sync_ff
// Purpose  : Multi-stage 1-bit synchronizer with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    localparam int c_stages = (STAGES < 2) ? 2 : STAGES;

    logic [c_stages-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_stages-2:0], i_d};
        end
    end

    assign o_q = r_sync[c_stages-1];

endmodule

`default_nettype wire

// File: rtl/usb_clk_rst_gen.sv
// ============================================================================
// Module   : usb_clk_rst_gen
// Purpose  : USB core reset sequencer from PLL lock, plus bit strobe and SOF tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_clk_rst_gen
    import usb_clk_pkg::*;
#(
    parameter int CLK_DIV     = USB_FS_CLK_DIV,
    parameter int SOF_CYCLES  = USB_SOF_CYCLES_48M,
    parameter int LOCK_STABLE = 1024,
    parameter int RST_HOLD    = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pll_lock_i,
    input  logic lock_lost_clr_i,
    output logic usb_rst_o,
    output logic locked_o,
    output logic bit_stb_o,
    output logic sof_tick_o,
    output logic lock_lost_o
);

    localparam int c_stab_w = cnt_width(LOCK_STABLE);
    localparam int c_hold_w = cnt_width(RST_HOLD);
    localparam int c_bit_w  = cnt_width(CLK_DIV);
    localparam int c_sof_w  = cnt_width(SOF_CYCLES);

    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_HOLD - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(CLK_DIV - 1);
    localparam logic [c_sof_w-1:0]  c_sof_last  = c_sof_w'(SOF_CYCLES - 1);

    logic                w_lock_s;
    usb_clk_state_e      r_state,    w_state_nxt;
    logic [c_stab_w-1:0] r_stab_cnt, w_stab_cnt_nxt;
    logic [c_hold_w-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [c_bit_w-1:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [c_sof_w-1:0]  r_sof_cnt,  w_sof_cnt_nxt;
    logic                r_lock_lost, w_lock_lost_nxt;
    logic                w_stay_run;
    logic                r_usb_rst;
    logic                r_locked;
    logic                r_bit_stb;
    logic                r_sof_tick;

    usb_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (pll_lock_i),
        .o_q (w_lock_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_stab_cnt_nxt  = r_stab_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_lock_lost_nxt = r_lock_lost;

        case (r_state)
            WAIT_LOCK: begin
                w_hold_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_stab_cnt_nxt = '0;
                end else if (r_stab_cnt == c_stab_last) begin
                    w_state_nxt    = HOLDOFF;
                    w_stab_cnt_nxt = '0;
                end else begin
                    w_stab_cnt_nxt = r_stab_cnt + 1'b1;
                end
            end
            HOLDOFF: begin
                w_stab_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt    = WAIT_LOCK;
                    w_hold_cnt_nxt = '0;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt    = RUN;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            RUN: begin
                w_stab_cnt_nxt = '0;
                w_hold_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt    = WAIT_LOCK;
                w_stab_cnt_nxt = '0;
                w_hold_cnt_nxt = '0;
            end
        endcase

        // A loss on the same edge as a clear request must remain visible.
        if ((r_state == RUN) && !w_lock_s) begin
            w_lock_lost_nxt = 1'b1;
        end else if (lock_lost_clr_i) begin
            w_lock_lost_nxt = 1'b0;
        end

        // Dividers only advance while RUN persists across the edge.
        w_stay_run    = (r_state == RUN) && (w_state_nxt == RUN);
        w_bit_cnt_nxt = '0;
        w_sof_cnt_nxt = '0;
        if (w_stay_run) begin
            w_bit_cnt_nxt = (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
            w_sof_cnt_nxt = (r_sof_cnt == c_sof_last) ? '0 : r_sof_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= WAIT_LOCK;
            r_stab_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_sof_cnt   <= '0;
            r_lock_lost <= 1'b0;
            r_usb_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_bit_stb   <= 1'b0;
            r_sof_tick  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stab_cnt  <= w_stab_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_sof_cnt   <= w_sof_cnt_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_usb_rst   <= (w_state_nxt != RUN);
            r_locked    <= (w_state_nxt == RUN);
            r_bit_stb   <= w_stay_run && (r_bit_cnt == c_bit_last);
            r_sof_tick  <= w_stay_run && (r_sof_cnt == c_sof_last);
        end
    end

    assign usb_rst_o   = r_usb_rst;
    assign locked_o    = r_locked;
    assign bit_stb_o   = r_bit_stb;
    assign sof_tick_o  = r_sof_tick;
    assign lock_lost_o = r_lock_lost;

endmodule

`default_nettype wire

// File: tb/tb_usb_clk_rst_gen.sv
// ============================================================================
// Module   : tb_usb_clk_rst_gen
// Purpose  : Directed self-checking bench for usb_clk_rst_gen (small parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_clk_rst_gen;

    localparam int c_clk_div     = 4;
    localparam int c_sof_cycles  = 20;
    localparam int c_lock_stable = 8;
    localparam int c_rst_hold    = 4;
    localparam int c_sync_stages = 2;
    localparam int c_run_lat     = c_sync_stages + c_lock_stable + c_rst_hold;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic lock_lost_clr;
    logic usb_rst;
    logic locked;
    logic bit_stb;
    logic sof_tick;
    logic lock_lost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb_clk_rst_gen #(
        .CLK_DIV     (c_clk_div),
        .SOF_CYCLES  (c_sof_cycles),
        .LOCK_STABLE (c_lock_stable),
        .RST_HOLD    (c_rst_hold),
        .SYNC_STAGES (c_sync_stages)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pll_lock_i      (pll_lock),
        .lock_lost_clr_i (lock_lost_clr),
        .usb_rst_o       (usb_rst),
        .locked_o        (locked),
        .bit_stb_o       (bit_stb),
        .sof_tick_o      (sof_tick),
        .lock_lost_o     (lock_lost)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (usb_rst === 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check_eq(tag, n, c_run_lat);
        check_eq({tag, "_locked"}, locked, 1);
    endtask

    task automatic check_strobes(input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            step(1);
            check_eq("bit_stb", bit_stb, (k % c_clk_div) == 0);
            check_eq("sof_tick", sof_tick, (k % c_sof_cycles) == 0);
            check_eq("run_locked", locked, 1);
        end
    endtask

    task automatic check_idle(input string tag, input int ncyc, input logic exp_lost);
        for (int k = 0; k < ncyc; k++) begin
            step(1);
            check_eq({tag, "_usb_rst"}, usb_rst, 1);
            check_eq({tag, "_locked"}, locked, 0);
            check_eq({tag, "_lost"}, lock_lost, exp_lost);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        pll_lock      = 1'b0;
        lock_lost_clr = 1'b0;
        step(3);
        rst = 1'b0;

        check_eq("rst_usb_rst", usb_rst, 1);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_bit_stb", bit_stb, 0);
        check_eq("rst_sof_tick", sof_tick, 0);
        check_eq("rst_lost", lock_lost, 0);

        // Clean lock, then 40 RUN cycles of strobes.
        pll_lock = 1'b1;
        wait_run("clean_lat");
        check_eq("clean_bit_c0", bit_stb, 0);
        check_strobes(40);

        // Loss in RUN, timed so the leaving edge would otherwise carry a bit strobe.
        step(1);
        pll_lock = 1'b0;
        step(2);
        check_eq("loss_still_run", usb_rst, 0);
        step(1);
        check_eq("loss_usb_rst", usb_rst, 1);
        check_eq("loss_locked", locked, 0);
        check_eq("loss_lost", lock_lost, 1);
        check_eq("loss_bit_stb", bit_stb, 0);
        check_eq("loss_sof_tick", sof_tick, 0);
        check_idle("loss_idle", 5, 1'b1);

        // Relock: counters restart from zero.
        pll_lock = 1'b1;
        wait_run("relock_lat");
        check_strobes(20);
        check_eq("relock_lost_sticky", lock_lost, 1);

        // Reset mid-RUN.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("mrst_usb_rst", usb_rst, 1);
        check_eq("mrst_locked", locked, 0);
        check_eq("mrst_bit_stb", bit_stb, 0);
        check_eq("mrst_sof_tick", sof_tick, 0);
        check_eq("mrst_lost", lock_lost, 0);
        wait_run("mrst_lat");
        check_strobes(8);

        // Clear on the same edge as a new loss: the set wins.
        pll_lock = 1'b0;
        step(2);
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check_eq("coll_usb_rst", usb_rst, 1);
        check_eq("coll_lost", lock_lost, 1);
        step(3);
        check_eq("coll_lost_hold", lock_lost, 1);
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check_eq("clr_lost", lock_lost, 0);

        // Glitchy lock never reaches the stability count.
        check_idle("pre_glitch", 6, 1'b0);
        pll_lock = 1'b1;
        check_idle("glitch_h1", 5, 1'b0);
        pll_lock = 1'b0;
        check_idle("glitch_l", 2, 1'b0);
        pll_lock = 1'b1;
        check_idle("glitch_h2", 5, 1'b0);
        pll_lock = 1'b0;
        check_idle("glitch_tail", 4, 1'b0);

        // Loss during HOLDOFF returns to WAIT_LOCK without flagging a loss.
        pll_lock = 1'b1;
        step(c_sync_stages + c_lock_stable);
        pll_lock = 1'b0;
        check_idle("hold_loss", 10, 1'b0);
        pll_lock = 1'b1;
        wait_run("hold_relock_lat");
        check_eq("hold_relock_lost", lock_lost, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
